// File: rtl/uart_fifo_pkg.sv
// Shared definitions for the parametrised UART FIFO: width helpers, status-register
// error bit positions and the reset level. Used by both FIFO build modes (UART_FIFO_FWFT_EN).
package uart_fifo_pkg;

  localparam logic RESET_LEVEL = 1'b0;

  // Bit positions of the sticky error flags inside the APB status register
  localparam int ERR_OVERFLOW_BIT  = 0;
  localparam int ERR_UNDERFLOW_BIT = 1;

  typedef struct packed {
    logic underflow;
    logic overflow;
  } err_flags_t;

  function automatic int fifo_clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

  function automatic int ptr_width(input int depth);
    return fifo_clog2(depth);
  endfunction

  // Count needs one extra bit so that a completely full FIFO (DEPTH) is representable
  function automatic int cnt_width(input int depth);
    return fifo_clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_fifo_sync_param_if.sv
// Handshake/status bundle between the APB register block (master) and the FIFO (slave).
// Identical for both build modes (UART_FIFO_FWFT_EN only changes data_out timing).
interface uart_fifo_sync_param_if
  import uart_fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 128
);
  localparam int CW = cnt_width(DEPTH);

  logic [WIDTH-1:0] data_in;
  logic             write_n;
  logic             read_n;
  logic             flush;
  logic             clr_err;
  logic [CW-1:0]    level;
  logic [CW-1:0]    afull_th;
  logic [CW-1:0]    aempty_th;

  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             geq_th;
  logic             afull;
  logic             aempty;
  logic             overflow;
  logic             underflow;

  modport master (
    output data_in, write_n, read_n, flush, clr_err, level, afull_th, aempty_th,
    input  data_out, data_valid, count, full, empty, geq_th, afull, aempty,
           overflow, underflow
  );

  modport slave (
    input  data_in, write_n, read_n, flush, clr_err, level, afull_th, aempty_th,
    output data_out, data_valid, count, full, empty, geq_th, afull, aempty,
           overflow, underflow
  );

endinterface

// File: rtl/uart_fifo_mem.sv
// Simple dual-port WIDTH x DEPTH RAM with synchronous write and registered read.
// No reset so it maps onto LSRAM/uSRAM; read returns the pre-write contents on a collision.
module uart_fifo_mem
  import uart_fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 128,
  parameter int AW    = ptr_width(DEPTH)
) (
  input  logic             clock,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clock) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/uart_fifo_sync_param.sv
// Parametrised single-clock UART FIFO with occupancy, thresholds, flush and sticky errors.
// Define UART_FIFO_FWFT_EN for first-word-fall-through; default is one-cycle read latency.
module uart_fifo_sync_param
  import uart_fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 128
) (
  input  logic                   clock,
  input  logic                   reset_n,
  uart_fifo_sync_param_if.slave  bus
);

  localparam int AW = ptr_width(DEPTH);
  localparam int CW = cnt_width(DEPTH);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  err_flags_t       err_q, err_d;
  logic             valid_q;
  logic             is_full, is_empty;
  logic             rd_acc, wr_acc, ovf_set, unf_set;
  logic             mem_rd_en;
  logic [AW-1:0]    mem_rd_addr;
  logic [WIDTH-1:0] mem_rd_data;
  logic [WIDTH-1:0] data_out;

  assign is_full  = (count_q == FULL_COUNT);
  assign is_empty = (count_q == '0);

  // A read frees a slot in the same cycle, so a full FIFO can still take a write alongside it
  assign rd_acc  = !bus.flush && !bus.read_n && !is_empty;
  assign wr_acc  = !bus.flush && !bus.write_n && (!is_full || rd_acc);
  assign ovf_set = !bus.flush && !bus.write_n && !wr_acc;
  assign unf_set = !bus.flush && !bus.read_n && is_empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    err_d    = err_q;
    if (bus.clr_err) begin
      err_d = '0;
    end
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (rd_acc) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (wr_acc && !rd_acc) begin
        count_d = count_q + CW'(1);
      end else if (rd_acc && !wr_acc) begin
        count_d = count_q - CW'(1);
      end
      if (ovf_set) begin
        err_d.overflow = 1'b1;
      end
      if (unf_set) begin
        err_d.underflow = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset_n == RESET_LEVEL) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  uart_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clock     (clock),
    .wr_en_i   (wr_acc),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (bus.data_in),
    .rd_en_i   (mem_rd_en),
    .rd_addr_i (mem_rd_addr),
    .rd_data_o (mem_rd_data)
  );

`ifdef UART_FIFO_FWFT_EN
  logic             byp_sel_d, byp_sel_q;
  logic [WIDTH-1:0] byp_q;
  logic [WIDTH-1:0] hold_q;
  logic [WIDTH-1:0] head;

  // RAM is re-read at the next head address every cycle; a write landing on that
  // address this cycle is not visible through the RAM yet, so it goes via the bypass
  assign mem_rd_en   = 1'b1;
  assign mem_rd_addr = rd_ptr_d;
  assign byp_sel_d   = wr_acc && (wr_ptr_q == rd_ptr_d);
  assign head        = byp_sel_q ? byp_q : mem_rd_data;
  assign data_out    = valid_q ? head : hold_q;

  always_ff @(posedge clock) begin
    if (reset_n == RESET_LEVEL) begin
      byp_sel_q <= 1'b0;
      byp_q     <= '0;
      hold_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      byp_sel_q <= byp_sel_d;
      if (byp_sel_d) begin
        byp_q <= bus.data_in;
      end
      hold_q  <= data_out;
      valid_q <= (count_d != '0);
    end
  end
`else
  logic seen_q;

  // The RAM output register only moves on a pop, so it already holds between pops;
  // seen_q just masks the unreset RAM output until the first pop after reset
  assign mem_rd_en   = rd_acc;
  assign mem_rd_addr = rd_ptr_q;
  assign data_out    = seen_q ? mem_rd_data : '0;

  always_ff @(posedge clock) begin
    if (reset_n == RESET_LEVEL) begin
      seen_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      if (rd_acc) begin
        seen_q <= 1'b1;
      end
      valid_q <= rd_acc;
    end
  end
`endif

  assign bus.data_out   = data_out;
  assign bus.data_valid = valid_q;
  assign bus.count      = count_q;
  assign bus.full       = is_full;
  assign bus.empty      = is_empty;
  assign bus.geq_th     = (count_q >= bus.level);
  assign bus.afull      = (count_q >= bus.afull_th);
  assign bus.aempty     = (count_q <= bus.aempty_th);
  assign bus.overflow   = err_q[ERR_OVERFLOW_BIT];
  assign bus.underflow  = err_q[ERR_UNDERFLOW_BIT];

endmodule
